// File: rtl/sound_request_arbiter.sv
// Sound request arbiter: per-channel pending requests with tone keys, fixed
// lowest-index priority, and an IDLE/PLAY/GAP sequencer that drives a tone
// generator for a tick-counted note duration followed by a silent gap.
module sound_request_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int KEY_W      = 4,
  parameter int HOLD_TICKS = 8,
  parameter int GAP_TICKS  = 1,
  parameter int PREEMPT    = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [NUM_CH-1:0]             sound_req,
  input  logic [NUM_CH-1:0][KEY_W-1:0]  tone_key_in,
  output logic                          sound_enable,
  output logic [KEY_W-1:0]              tone_key,
  output logic [CH_W-1:0]               active_ch,
  output logic                          busy,
  output logic                          req_merged
);

  localparam int CNT_MAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [NUM_CH-1:0]              r_pending;
  logic [NUM_CH-1:0][KEY_W-1:0]   r_keys;
  logic                           r_sound_enable;
  logic [KEY_W-1:0]               r_tone_key;
  logic [CH_W-1:0]                r_active_ch;
  logic                           r_busy;
  logic                           r_req_merged;

  logic                           w_any;
  logic [CH_W-1:0]                w_win;
  logic                           w_preempt;
  logic                           w_grant;
  logic [NUM_CH-1:0]              w_grant_mask;
  logic [CNT_W-1:0]               w_cnt_inc;

  // Priority encoder: lowest pending index wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_any = 1'b0;
    w_win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_any = 1'b1;
        w_win = CH_W'(i);
      end
    end
  end

  // Grant decision for this edge and the saturating counter increment.
  always_comb begin
    w_preempt    = (PREEMPT != 0) && (r_state == S_PLAY) && w_any && (w_win < r_active_ch);
    w_grant      = ((r_state == S_IDLE) && w_any) || w_preempt;
    w_grant_mask = w_grant ? (NUM_CH'(1) << w_win) : '0;
    w_cnt_inc    = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : r_cnt + CNT_W'(1);
  end

  // Pending bits, captured keys and the merge pulse. A new request on the
  // channel being granted re-arms it with the new key, so it is not a merge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_pending    <= '0;
      // NOTE: the key bank is small and its reset value is observable, so it
      // is cleared along with the pending bits.
      r_keys       <= '0;
      r_req_merged <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sound_req[i]) begin
          r_pending[i] <= 1'b1;
          r_keys[i]    <= tone_key_in[i];
        end else if (w_grant_mask[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
      r_req_merged <= |(sound_req & r_pending & ~w_grant_mask);
    end
  end

  // Note sequencer with registered outputs: IDLE -> PLAY -> GAP -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_sound_enable <= 1'b0;
      r_tone_key     <= '0;
      r_active_ch    <= '0;
      r_busy         <= 1'b0;
    end else if (w_grant) begin
      // Start (or restart on preemption) a note for the winning channel.
      r_state        <= S_PLAY;
      r_cnt          <= '0;
      r_sound_enable <= 1'b1;
      r_tone_key     <= r_keys[w_win];
      r_active_ch    <= w_win;
      r_busy         <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
        end
        S_PLAY: begin
          if (tick) begin
            if (w_cnt_inc >= CNT_W'(HOLD_TICKS)) begin
              r_cnt          <= '0;
              r_sound_enable <= 1'b0;
              r_tone_key     <= '0;
              if (GAP_TICKS == 0) begin
                r_state     <= S_IDLE;
                r_active_ch <= '0;
                r_busy      <= 1'b0;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (w_cnt_inc >= CNT_W'(GAP_TICKS)) begin
              r_state     <= S_IDLE;
              r_cnt       <= '0;
              r_active_ch <= '0;
              r_busy      <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_cnt          <= '0;
          r_sound_enable <= 1'b0;
          r_tone_key     <= '0;
          r_active_ch    <= '0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign sound_enable = r_sound_enable;
  assign tone_key     = r_tone_key;
  assign active_ch    = r_active_ch;
  assign busy         = r_busy;
  assign req_merged   = r_req_merged;

endmodule

// File: doc/sound_request_arbiter.md
SOUND_REQUEST_ARBITER -- requirements
Module: sound_request_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of sound request channels (legal 2..8).
REQ-002 Parameter KEY_W, default 4, tone key width in bits.
REQ-003 Parameter HOLD_TICKS, default 8, note duration in tick pulses (legal >=1).
REQ-004 Parameter GAP_TICKS, default 1, silent gap after a note in tick pulses (legal >=0).
REQ-005 Parameter PREEMPT, default 1; 1 = a higher-priority request interrupts the current note, 0 = notes always complete.
REQ-006 clk  input  1  single clock, all logic rising-edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 tick  input  1  one-cycle timebase strobe for duration counting.
REQ-009 sound_req  input  NUM_CH  per-channel one-cycle request pulse.
REQ-010 tone_key_in  input  NUM_CH x KEY_W  per-channel key, sampled with its sound_req bit.
REQ-011 sound_enable  output  1  tone generator enable.
REQ-012 tone_key  output  KEY_W  key currently played.
REQ-013 active_ch  output  clog2(NUM_CH)  index of the channel being played.
REQ-014 busy  output  1  high in PLAY or GAP.
REQ-015 req_merged  output  1  one-cycle pulse: a request hit an already-pending channel.

Function
REQ-016 Each channel i SHALL keep a pending bit and a KEY_W key register; sound_req[i]=1 sets pending[i] and captures tone_key_in[i].
REQ-017 A request to an already-pending channel SHALL overwrite the key, keep the request pending, and pulse req_merged the next cycle.
REQ-018 Priority SHALL be fixed: the lowest pending index wins.
REQ-019 FSM states SHALL be IDLE, PLAY and GAP; all outputs are registered.
REQ-020 IDLE: if any pending bit is set, go to PLAY next edge; latch the winner into active_ch and its key into tone_key; clear that pending bit; clear the tick counter.
REQ-021 Latency: sound_req at edge N in IDLE SHALL give sound_enable=1 after edge N+2.
REQ-022 PLAY: sound_enable=1; the counter increments on tick; on the tick that brings the count to HOLD_TICKS, go to GAP, or to IDLE when GAP_TICKS=0.
REQ-023 PLAY with PREEMPT=1 and any pending index < active_ch: on the next edge, switch to that channel, load its key, clear its pending bit, restart the counter, and stay in PLAY with no gap.
REQ-024 A request from a channel of equal or lower priority than active_ch SHALL stay pending and never interrupt.
REQ-025 GAP: sound_enable=0, tone_key=0; count GAP_TICKS ticks, then go to IDLE.
REQ-026 In IDLE, sound_enable=0, tone_key=0, active_ch=0 and busy=0.
REQ-027 Simultaneous grant and new request on the same channel: the grant SHALL consume the old key; the new request stays pending with the new key; req_merged is not pulsed.
REQ-028 Counters SHALL saturate rather than wrap; tick pulses outside PLAY and GAP are ignored.

Reset
REQ-029 With reset high at an edge, the state SHALL become IDLE and all pending bits, keys and counters 0.
REQ-030 After that edge, sound_enable=0, tone_key=0, active_ch=0, busy=0 and req_merged=0.
REQ-031 Reset SHALL win over sound_req in the same cycle; the request is lost.
REQ-032 Reset in PLAY or GAP SHALL silence the output at the next edge.

Verification
(NUM_CH=4, KEY_W=4, HOLD_TICKS=3, GAP_TICKS=1, tick=1 unless stated)
REQ-033 Single request: ch2 with key 0x5 at edge 0 -> sound_enable high and tone_key=0x5, active_ch=2 for edges 2..4, low at edge 5 (GAP), busy low from edge 6.
REQ-034 Simultaneous requests: ch1 key 0x3 and ch3 key 0xA at once -> 0x3 plays 3 cycles, 1 gap cycle, then 0xA plays 3 cycles.
REQ-035 Preemption: ch3 playing, ch0 key 0x7 requested -> tone_key=0x7 and active_ch=0 two edges later with no low cycle in between; with PREEMPT=0, ch3 completes and 0x7 plays after the gap.
REQ-036 Merge: ch1 requested with 0x2 then 0x9 while ch0 plays -> req_merged pulses once; ch1 later plays 0x9.
REQ-037 Tick gating: tick every 4th cycle -> PLAY lasts 3 tick pulses (about 12 cycles); extra ticks in IDLE change nothing.
REQ-038 Reset mid-PLAY with ch2 also pending -> all outputs 0 next edge; ch2 never plays.
